cache_ctl_dm: RTL and testbench

//  Parametrised direct-mapped cache controller with built-in tag/valid/dirty/data storage.

---
 rtl/cache_ctl_dm.sv | 246 ++++++++++++++++++++++++
 tb/tb_cache_ctl_dm.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctl_dm.sv
// Direct-mapped cache controller with internal tag/valid/dirty/data storage.
// One registered response per accepted request; inv_all walks and clears every line.
module cache_ctl_dm #(
  parameter int TAG_W   = 5,
  parameter int INDEX_W = 4,
  parameter int WORD_W  = 2,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              comp,
  input  logic              write,
  input  logic [INDEX_W-1:0] index,
  input  logic [WORD_W-1:0]  word,
  input  logic [TAG_W-1:0]   tag_in,
  input  logic [DATA_W-1:0]  data_in,
  input  logic              valid_in,
  input  logic              inv_all,
  output logic              resp_valid,
  output logic              hit,
  output logic              dirty,
  output logic [TAG_W-1:0]   tag_out,
  output logic [DATA_W-1:0]  data_out,
  output logic              valid,
  output logic              busy
);

  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << WORD_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    RESP   = 2'd2,
    INVAL  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [INDEX_W-1:0]  cnt_q, cnt_d;
  logic                comp_q, comp_d;
  logic                write_q, write_d;
  logic [INDEX_W-1:0]  index_q, index_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                vin_q, vin_d;
  logic [LINES-1:0]    valid_arr_q, valid_arr_d;
  logic [LINES-1:0]    dirty_arr_q, dirty_arr_d;

  // Lookup results are parked here so the visible outputs only move with resp_valid.
  logic                rd_hit_q, rd_hit_d;
  logic                rd_dirty_q, rd_dirty_d;
  logic [TAG_W-1:0]    rd_tag_q, rd_tag_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;

  logic                resp_valid_q, resp_valid_d;
  logic                hit_q, hit_d;
  logic                dirty_q, dirty_d;
  logic [TAG_W-1:0]    tag_out_q, tag_out_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;

  logic [TAG_W-1:0]    tag_mem [LINES];
  logic [DATA_W-1:0]   data_mem [LINES*WORDS];

  logic                tag_we_s;
  logic                data_we_s;
  logic [TAG_W-1:0]    line_tag_s;
  logic [DATA_W-1:0]   line_data_s;
  logic                line_valid_s;
  logic                line_dirty_s;
  logic                hit_s;

  assign req_ready  = (state_q == IDLE) && !inv_all;
  assign resp_valid = resp_valid_q;
  assign hit        = hit_q;
  assign dirty      = dirty_q;
  assign tag_out    = tag_out_q;
  assign data_out   = data_out_q;
  assign valid      = valid_q;
  assign busy       = busy_q;

  assign line_tag_s   = tag_mem[index_q];
  assign line_data_s  = data_mem[{index_q, word_q}];
  assign line_valid_s = valid_arr_q[index_q];
  assign line_dirty_s = dirty_arr_q[index_q];
  assign hit_s        = comp_q && line_valid_s && (line_tag_s == tag_q);

  // Next-state, request capture, write commit and response staging.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    comp_d       = comp_q;
    write_d      = write_q;
    index_d      = index_q;
    word_d       = word_q;
    tag_d        = tag_q;
    data_d       = data_q;
    vin_d        = vin_q;
    valid_arr_d  = valid_arr_q;
    dirty_arr_d  = dirty_arr_q;
    rd_hit_d     = rd_hit_q;
    rd_dirty_d   = rd_dirty_q;
    rd_tag_d     = rd_tag_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = rd_valid_q;
    resp_valid_d = 1'b0;
    hit_d        = hit_q;
    dirty_d      = dirty_q;
    tag_out_d    = tag_out_q;
    data_out_d   = data_out_q;
    valid_d      = valid_q;
    tag_we_s     = 1'b0;
    data_we_s    = 1'b0;

    case (state_q)
      IDLE: begin
        if (inv_all) begin
          state_d = INVAL;
          cnt_d   = '0;
        end else if (req_valid) begin
          comp_d  = comp;
          write_d = write;
          index_d = index;
          word_d  = word;
          tag_d   = tag_in;
          data_d  = data_in;
          vin_d   = valid_in;
          state_d = LOOKUP;
        end else begin
          state_d = IDLE;
        end
      end
      LOOKUP: begin
        rd_hit_d   = hit_s;
        rd_dirty_d = line_dirty_s;
        rd_tag_d   = line_tag_s;
        rd_data_d  = line_data_s;
        rd_valid_d = line_valid_s;
        if (write_q && !comp_q) begin
          tag_we_s             = 1'b1;
          data_we_s            = 1'b1;
          valid_arr_d[index_q] = vin_q;
          dirty_arr_d[index_q] = 1'b0;
        end else if (write_q && hit_s) begin
          data_we_s            = 1'b1;
          dirty_arr_d[index_q] = 1'b1;
        end else begin
          data_we_s = 1'b0;
        end
        state_d = RESP;
      end
      RESP: begin
        resp_valid_d = 1'b1;
        hit_d        = rd_hit_q;
        dirty_d      = rd_dirty_q;
        tag_out_d    = rd_tag_q;
        data_out_d   = rd_data_q;
        valid_d      = rd_valid_q;
        state_d      = IDLE;
      end
      INVAL: begin
        valid_arr_d[cnt_q] = 1'b0;
        dirty_arr_d[cnt_q] = 1'b0;
        if (cnt_q == INDEX_W'(LINES - 1)) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + INDEX_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // Control, valid/dirty bits and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      comp_q       <= 1'b0;
      write_q      <= 1'b0;
      index_q      <= '0;
      word_q       <= '0;
      tag_q        <= '0;
      data_q       <= '0;
      vin_q        <= 1'b0;
      valid_arr_q  <= '0;
      dirty_arr_q  <= '0;
      rd_hit_q     <= 1'b0;
      rd_dirty_q   <= 1'b0;
      rd_tag_q     <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      hit_q        <= 1'b0;
      dirty_q      <= 1'b0;
      tag_out_q    <= '0;
      data_out_q   <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      comp_q       <= comp_d;
      write_q      <= write_d;
      index_q      <= index_d;
      word_q       <= word_d;
      tag_q        <= tag_d;
      data_q       <= data_d;
      vin_q        <= vin_d;
      valid_arr_q  <= valid_arr_d;
      dirty_arr_q  <= dirty_arr_d;
      rd_hit_q     <= rd_hit_d;
      rd_dirty_q   <= rd_dirty_d;
      rd_tag_q     <= rd_tag_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      resp_valid_q <= resp_valid_d;
      hit_q        <= hit_d;
      dirty_q      <= dirty_d;
      tag_out_q    <= tag_out_d;
      data_out_q   <= data_out_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
    end
  end

  // Tag/data arrays carry no reset; the enables drop as soon as reset forces IDLE.
  always_ff @(posedge clk) begin
    if (tag_we_s) begin
      tag_mem[index_q] <= tag_q;
    end
    if (data_we_s) begin
      data_mem[{index_q, word_q}] <= data_q;
    end
  end

endmodule

// File: tb/tb_cache_ctl_dm.sv
// Directed self-checking bench for cache_ctl_dm with hand-computed expectations.
module tb_cache_ctl_dm;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        comp;
  logic        write;
  logic [3:0]  index;
  logic [1:0]  word;
  logic [4:0]  tag_in;
  logic [15:0] data_in;
  logic        valid_in;
  logic        inv_all;
  logic        resp_valid;
  logic        hit;
  logic        dirty;
  logic [4:0]  tag_out;
  logic [15:0] data_out;
  logic        valid;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  cache_ctl_dm dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .comp      (comp),
    .write     (write),
    .index     (index),
    .word      (word),
    .tag_in    (tag_in),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .inv_all   (inv_all),
    .resp_valid(resp_valid),
    .hit       (hit),
    .dirty     (dirty),
    .tag_out   (tag_out),
    .data_out  (data_out),
    .valid     (valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the response cycle.
  task automatic do_req(input logic c, input logic w, input logic [3:0] idx, input logic [1:0] wd,
                        input logic [4:0] tg, input logic [15:0] d, input logic vi);
    int n;
    comp = c; write = w; index = idx; word = wd; tag_in = tg; data_in = d; valid_in = vi;
    req_valid = 1'b1;
    #1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    check_eq("ready_wait", 32'(n < 20), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    comp = ~c; tag_in = ~tg; data_in = ~d;
    n = 0;
    while (!resp_valid && n < 6) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("latency", 32'(n), 32'd2);
  endtask

  logic        saw_resp;
  int          bcnt;
  int          k, r, cyc;
  logic        acc;
  int          acc_cyc [3];
  int          resp_cyc [3];

  initial begin
    rst = 1'b0; req_valid = 1'b0; comp = 1'b0; write = 1'b0; index = 4'd0; word = 2'd0;
    tag_in = 5'd0; data_in = 16'd0; valid_in = 1'b0; inv_all = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_outs", {hit, dirty, valid, tag_out, data_out}, 32'd0);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    check_eq("idle_ready", 32'(req_ready), 32'd1);

    // 1: compare read on empty line
    do_req(1'b1, 1'b0, 4'd3, 2'd1, 5'h0A, 16'h0000, 1'b0);
    check_eq("t1_hit", 32'(hit), 32'd0);
    check_eq("t1_valid", 32'(valid), 32'd0);
    check_eq("t1_dirty", 32'(dirty), 32'd0);
    @(posedge clk); #1;
    check_eq("t1_pulse_end", 32'(resp_valid), 32'd0);

    // 2: access write then compare read
    do_req(1'b0, 1'b1, 4'd3, 2'd1, 5'h0A, 16'hBEEF, 1'b1);
    check_eq("t2_aw_hit", 32'(hit), 32'd0);
    check_eq("t2_aw_prevalid", 32'(valid), 32'd0);
    do_req(1'b1, 1'b0, 4'd3, 2'd1, 5'h0A, 16'h0000, 1'b0);
    check_eq("t2_hit", 32'(hit), 32'd1);
    check_eq("t2_valid", 32'(valid), 32'd1);
    check_eq("t2_data", 32'(data_out), 32'hBEEF);
    check_eq("t2_dirty", 32'(dirty), 32'd0);
    check_eq("t2_tag", 32'(tag_out), 32'h0A);

    // 3: compare write hit, reread, compare write miss, reread
    do_req(1'b1, 1'b1, 4'd3, 2'd1, 5'h0A, 16'h1234, 1'b0);
    check_eq("t3_cw_hit", 32'(hit), 32'd1);
    check_eq("t3_cw_predata", 32'(data_out), 32'hBEEF);
    check_eq("t3_cw_predirty", 32'(dirty), 32'd0);
    do_req(1'b1, 1'b0, 4'd3, 2'd1, 5'h0A, 16'h0000, 1'b0);
    check_eq("t3_hit", 32'(hit), 32'd1);
    check_eq("t3_dirty", 32'(dirty), 32'd1);
    check_eq("t3_data", 32'(data_out), 32'h1234);
    do_req(1'b1, 1'b1, 4'd3, 2'd1, 5'h0B, 16'h5555, 1'b0);
    check_eq("t3_miss_hit", 32'(hit), 32'd0);
    check_eq("t3_miss_tag", 32'(tag_out), 32'h0A);
    do_req(1'b1, 1'b0, 4'd3, 2'd1, 5'h0A, 16'h0000, 1'b0);
    check_eq("t3_reread", 32'(data_out), 32'h1234);

    // 4: fill all lines, dirty one, then bulk invalidate
    for (int i = 0; i < 16; i++) begin
      do_req(1'b0, 1'b1, 4'(i), 2'd0, 5'(i), 16'hC000 + 16'(i), 1'b1);
    end
    do_req(1'b1, 1'b1, 4'd5, 2'd0, 5'd5, 16'h5A5A, 1'b0);
    check_eq("t4_dirty_setup_hit", 32'(hit), 32'd1);
    inv_all = 1'b1; req_valid = 1'b1;
    comp = 1'b1; write = 1'b0; index = 4'd0; tag_in = 5'd0;
    #1;
    check_eq("t4_ready_low", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    inv_all = 1'b0; req_valid = 1'b0;
    bcnt = 0; saw_resp = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (resp_valid) saw_resp = 1'b1;
      if (!busy) break;
      bcnt++;
      if (i == 5) check_eq("t4_ready_inval", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    check_eq("t4_busy_cycles", 32'(bcnt), 32'd16);
    check_eq("t4_no_resp", 32'(saw_resp), 32'd0);
    for (int i = 0; i < 16; i++) begin
      do_req(1'b0, 1'b0, 4'(i), 2'd0, 5'd0, 16'd0, 1'b0);
      check_eq("t4_line_valid", 32'(valid), 32'd0);
      check_eq("t4_line_dirty", 32'(dirty), 32'd0);
    end

    // 5: reset during LOOKUP of a compare write
    do_req(1'b0, 1'b1, 4'd7, 2'd0, 5'd3, 16'h1111, 1'b1);
    comp = 1'b1; write = 1'b1; index = 4'd7; word = 2'd0; tag_in = 5'd3; data_in = 16'h2222;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_eq("t5_busy_lookup", 32'(busy), 32'd1);
    #1 rst = 1'b0;
    #1;
    check_eq("t5_rst_resp", 32'(resp_valid), 32'd0);
    check_eq("t5_rst_busy", 32'(busy), 32'd0);
    check_eq("t5_rst_outs", {hit, dirty, valid, tag_out, data_out}, 32'd0);
    @(posedge clk); #3 rst = 1'b1;
    saw_resp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (resp_valid) saw_resp = 1'b1;
    end
    check_eq("t5_no_resp", 32'(saw_resp), 32'd0);
    do_req(1'b0, 1'b0, 4'd7, 2'd0, 5'd0, 16'd0, 1'b0);
    check_eq("t5_valid", 32'(valid), 32'd0);
    check_eq("t5_data_kept", 32'(data_out), 32'h1111);
    check_eq("t5_tag_kept", 32'(tag_out), 32'd3);

    // 6: three queued compare reads with req_valid held high
    for (int i = 0; i < 3; i++) begin
      do_req(1'b0, 1'b1, 4'(8 + i), 2'd0, 5'(8 + i), 16'hA000 + 16'(i), 1'b1);
    end
    @(posedge clk); #1;
    k = 0; r = 0; cyc = 0;
    while (r < 3 && cyc < 40) begin
      if (k < 3) begin
        comp = 1'b1; write = 1'b0; index = 4'(8 + k); word = 2'd0; tag_in = 5'(8 + k);
        data_in = 16'd0; req_valid = 1'b1;
      end else begin
        req_valid = 1'b0;
      end
      #1;
      acc = req_valid && req_ready;
      if (acc) acc_cyc[k] = cyc;
      if (resp_valid) begin
        check_eq("t6_hit", 32'(hit), 32'd1);
        check_eq("t6_data", 32'(data_out), 32'hA000 + 32'(r));
        resp_cyc[r] = cyc;
        r++;
      end
      @(posedge clk); #1;
      if (acc) k++;
      cyc++;
    end
    req_valid = 1'b0;
    check_eq("t6_resp_count", 32'(r), 32'd3);
    check_eq("t6_acc_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
    check_eq("t6_acc_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
    check_eq("t6_resp_gap1", 32'(resp_cyc[1] - resp_cyc[0]), 32'd3);
    check_eq("t6_resp_gap2", 32'(resp_cyc[2] - resp_cyc[1]), 32'd3);
    check_eq("t6_first_lat", 32'(resp_cyc[0] - acc_cyc[0]), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
